// File: rtl/start_seq_pkg.sv
// Shared types and default parameters for the start-edge sequencing controller.
package start_seq_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} seq_state_t;

  localparam int EDGES_REQ_DEF = 3;
  localparam int CNT_W_DEF     = 2;
  localparam int MAX_GAP_DEF   = 8;
  localparam int GAP_W_DEF     = 4;
endpackage

// File: rtl/start_seq_ctrl_if.sv
// Control/status bundle between the start sequencer and its environment.
interface start_seq_ctrl_if import start_seq_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic             start;
  logic             enable;
  logic             clear;
  logic             done_ack;
  logic             done;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output start, enable, clear, done_ack,
    input  done, busy, timeout, edge_cnt
  );

  modport slave (
    input  start, enable, clear, done_ack,
    output done, busy, timeout, edge_cnt
  );
endinterface

// File: rtl/start_seq_ctrl_rise_detect.sv
// Registered rising-edge detector; the reset value of the history register
// decides whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/start_seq_ctrl.sv
// Counts rising edges of start; after EDGES_REQ edges with bounded gaps it
// holds done until acknowledged, otherwise it times out back to IDLE.
module start_seq_ctrl import start_seq_pkg::*; #(
  parameter int EDGES_REQ = EDGES_REQ_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_GAP   = MAX_GAP_DEF,
  parameter int GAP_W     = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  start_seq_ctrl_if.slave  bus
);
  seq_state_t       state;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap;
  logic             done_r;
  logic             busy_r;
  logic             timeout_r;

  rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.start),
    .rise (rise)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else if (bus.clear) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && bus.enable) begin
            cnt    <= CNT_W'(1);
            gap    <= '0;
            busy_r <= 1'b1;
            if (EDGES_REQ == 1) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= COUNT;
            end
          end
        end
        COUNT: begin
          // A rise on the expiry cycle takes precedence over the timeout.
          if (rise) begin
            cnt <= cnt_inc;
            gap <= '0;
            if (cnt_inc == CNT_W'(EDGES_REQ)) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end else if (MAX_GAP != 0 && gap == GAP_W'(MAX_GAP - 1)) begin
            state     <= IDLE;
            cnt       <= '0;
            gap       <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else if (MAX_GAP != 0) begin
            gap <= gap + GAP_W'(1);
          end
        end
        DONE: begin
          if (bus.done_ack) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          gap    <= '0;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.timeout  = timeout_r;
  assign bus.edge_cnt = cnt;
endmodule
